// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: radix-2 iterative sequencer for the RV32M multiply group.
// Operands are reduced to magnitudes when they are captured. One partial
// product is accumulated per clock. The sign is applied in a final pass, and
// the selected half of the product is registered with a one-cycle done pulse.
module mul_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result,
    output logic [2*XLEN-1:0]   product
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     ma, mb;
    logic                neg;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       count;

    // Operand decode. a is signed unless op is MULHU. b is signed only for MUL and MULH.
    logic                sa, sb, a_neg, b_neg, accept, last;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [2*XLEN-1:0]   pp;

    assign sa     = (op != 2'b11);
    assign sb     = ~op[1];
    assign a_neg  = sa & a[XLEN-1];
    assign b_neg  = sb & b[XLEN-1];
    // -2^(XLEN-1) negates to itself, which reads back correctly as an unsigned magnitude
    assign a_mag  = a_neg ? (~a + 1'b1) : a;
    assign b_mag  = b_neg ? (~b + 1'b1) : b;
    // A start that arrives together with a flush is dropped
    assign accept = (state == IDLE) && start && !flush;
    assign last   = (count == CW'(XLEN-1));
    assign pp     = {{XLEN{1'b0}}, ma} << count;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: flush aborts CALC and SIGN only. DONE always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (flush) state_nxt = IDLE;
                  else if (last) state_nxt = SIGN;
            SIGN: state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: busy covers the iterating states and the IDLE cycle that accepts a start
    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:       busy = accept;
            CALC, SIGN: busy = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // Datapath: capture on accept, shift-and-add in CALC, conditional negate in SIGN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= 2'b00;
            ma    <= '0;
            mb    <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= op;
                    ma    <= a_mag;
                    mb    <= b_mag;
                    neg   <= a_neg ^ b_neg;
                    acc   <= '0;
                    count <= '0;
                end
                CALC: if (!flush) begin
                    if (mb[count]) acc <= acc + pp;
                    count <= count + CW'(1);
                end
                SIGN: if (!flush && neg) acc <= ~acc + 1'b1;
                default: ;
            endcase
        end
    end

    // Result registers: loaded only on leaving DONE, so an aborted op leaves them unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            result  <= '0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (state == DONE) begin
                done    <= 1'b1;
                product <= acc;
                result  <= (op_q == 2'b00) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed vector table plus hand-built flush, re-start and reset sequences.
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [63:0] product;

    int n_vec = 0;
    int n_miss = 0;

    mul_seq_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .result(result), .product(product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [63:0] exp_prod;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start an op and count edges after the accepting edge until done is seen.
    // flush_at > 0 drives flush so that it is sampled at that edge.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int flush_at, output int lat, output bit seen);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        #1 chk("busy_on_accept", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0; op = ~op_i; a = ~a_i; b = $urandom;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            flush = (lat + 1 == flush_at);
            @(posedge clk); #1;
            flush = 1'b0;
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    vec_t vecs[9];
    int   lat;
    bit   seen;
    logic [31:0] prev_res;

    initial begin
        vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 64'h4000_0000_0000_0000};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0001};
        vecs[6] = '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[7] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 64'h0000_0001_0000_0000};
        vecs[8] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};

        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Table-driven vectors: latency, result and product
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, seen);
            chk($sformatf("v%0d_latency", i), seen ? 64'(lat) : 64'hDEAD, 64'd34);
            chk($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vecs[i].exp_res});
            chk($sformatf("v%0d_product", i), product, vecs[i].exp_prod);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_1cyc", i), {63'd0, done}, 64'd0);
        end

        // Flush at cycle 10: back to IDLE, no done, result unchanged
        prev_res = result;
        run_op(2'b00, 32'd9, 32'd9, 10, lat, seen);
        chk("flush_no_done", {63'd0, seen}, 64'd0);
        chk("flush_result_kept", {32'd0, result}, {32'd0, prev_res});
        chk("flush_idle", {63'd0, busy}, 64'd0);
        run_op(2'b00, 32'd6, 32'd7, -1, lat, seen);
        chk("after_flush_latency", seen ? 64'(lat) : 64'hDEAD, 64'd34);
        chk("after_flush_result", {32'd0, result}, 64'd42);

        // flush together with start in IDLE drops the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; a = 32'd5; b = 32'd5; op = 2'b00;
        #1 chk("flush_start_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", {63'd0, busy}, 64'd0);

        // flush in DONE does not suppress the done pulse
        run_op(2'b00, 32'd11, 32'd3, 34, lat, seen);
        chk("flush_done_latency", seen ? 64'(lat) : 64'hDEAD, 64'd34);
        chk("flush_done_result", {32'd0, result}, 64'd33);

        // start held every cycle with changing operands: only the first capture counts
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd5;
        @(posedge clk); #1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            a = $urandom; b = $urandom; op = 2'($urandom);
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        chk("restart_latency", seen ? 64'(lat) : 64'hDEAD, 64'd34);
        chk("restart_result", {32'd0, result}, 64'd35);
        a = 32'd3; b = 32'd4; op = 2'b00;
        #1 chk("restart_accept_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        chk("second_latency", seen ? 64'(lat) : 64'hDEAD, 64'd34);
        chk("second_result", {32'd0, result}, 64'd12);

        // Reset mid-CALC clears outputs immediately
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_product", product, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, -1, lat, seen);
        chk("postrst_latency", seen ? 64'(lat) : 64'hDEAD, 64'd34);
        chk("postrst_result", {32'd0, result}, 64'd0);
        chk("postrst_product", product, 64'h0000_0001_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
